// File: rtl/rv_test_monitor.sv
// rtl/rv_test_monitor.sv - end-of-test monitor snooping the RV32I register-file write port
module rv_test_monitor #(
  parameter int XLEN           = 32,
  parameter int DONE_REG       = 26,
  parameter int RESULT_REG     = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_en,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-1:0]  fail_testnum,
  output logic [CNT_W-1:0] cycles
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [XLEN-1:0]  ONE        = XLEN'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_PASS, S_FAIL, S_TIMEOUT
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DW-1:0]     drain_cnt;
  logic [XLEN-1:0]   result_sh, testnum_sh, result_nx, testnum_nx, fail_tn;
  logic              snoop, hit_done, hit_result, hit_testnum;
  logic              done_wr, timeout_hit, drain_last;

  // Register-file write decode; x0 never matches, even if an index parameter is 0
  always_comb begin
    snoop       = (state == S_RUN) || (state == S_DRAIN);
    hit_done    = snoop && wr_en && (wr_addr != 5'd0) && (wr_addr == 5'(DONE_REG));
    hit_result  = snoop && wr_en && (wr_addr != 5'd0) && (wr_addr == 5'(RESULT_REG));
    hit_testnum = snoop && wr_en && (wr_addr != 5'd0) && (wr_addr == 5'(TESTNUM_REG));
    done_wr     = (state == S_RUN) && hit_done && (wr_data == ONE);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    drain_last  = (drain_cnt == DRAIN_LAST);
    result_nx   = hit_result  ? wr_data : result_sh;
    testnum_nx  = hit_testnum ? wr_data : testnum_sh;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; clr beats every other transition, done beats timeout
  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (mon_en) state_nx = S_RUN;
        S_RUN: begin
          if (done_wr)          state_nx = S_DRAIN;
          else if (timeout_hit) state_nx = S_TIMEOUT;
        end
        S_DRAIN: if (drain_last) state_nx = (result_nx == ONE) ? S_PASS : S_FAIL;
        default: state_nx = state;
      endcase
    end
  end

  // Shadows, run/drain counters and verdict test number
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      drain_cnt  <= '0;
      result_sh  <= '0;
      testnum_sh <= '0;
      fail_tn    <= '0;
    end else if (clr) begin
      cnt        <= '0;
      drain_cnt  <= '0;
      result_sh  <= '0;
      testnum_sh <= '0;
      fail_tn    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          result_sh  <= '0;
          testnum_sh <= '0;
          drain_cnt  <= '0;
          if (mon_en) cnt <= '0;
        end
        S_RUN: begin
          result_sh  <= result_nx;
          testnum_sh <= testnum_nx;
          if (done_wr)               drain_cnt <= '0;
          else if (timeout_hit)      fail_tn   <= testnum_nx;
          else if (cnt != '1)        cnt       <= cnt + CNT_W'(1);
        end
        S_DRAIN: begin
          result_sh  <= result_nx;
          testnum_sh <= testnum_nx;
          if (drain_last) fail_tn   <= testnum_nx;
          else            drain_cnt <= drain_cnt + DW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
  assign pass         = (state == S_PASS);
  assign fail         = (state == S_FAIL) || (state == S_TIMEOUT);
  assign timeout      = (state == S_TIMEOUT);
  assign fail_testnum = fail_tn;
  assign cycles       = cnt;

endmodule

// File: tb/tb_rv_test_monitor.sv
// tb/tb_rv_test_monitor.sv - directed self-checking bench for rv_test_monitor
module tb_rv_test_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mon_en = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;

  int checks = 0;
  int errors = 0;

  // main instance: defaults
  logic m_busy, m_done, m_pass, m_fail, m_timeout;
  logic [31:0] m_tn, m_cyc;
  // timeout instance: TIMEOUT_CYCLES=50
  logic t_busy, t_done, t_pass, t_fail, t_timeout;
  logic [31:0] t_tn, t_cyc;
  // DONE_REG=0 instance
  logic z_busy, z_done, z_pass, z_fail, z_timeout;
  logic [31:0] z_tn, z_cyc;

  always #5 clk = ~clk;

  rv_test_monitor u_main (
    .clk(clk), .rst(rst), .mon_en(mon_en), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(m_busy), .done(m_done), .pass(m_pass), .fail(m_fail), .timeout(m_timeout),
    .fail_testnum(m_tn), .cycles(m_cyc)
  );

  rv_test_monitor #(.TIMEOUT_CYCLES(50)) u_to (
    .clk(clk), .rst(rst), .mon_en(mon_en), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(t_busy), .done(t_done), .pass(t_pass), .fail(t_fail), .timeout(t_timeout),
    .fail_testnum(t_tn), .cycles(t_cyc)
  );

  rv_test_monitor #(.DONE_REG(0)) u_z (
    .clk(clk), .rst(rst), .mon_en(mon_en), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(z_busy), .done(z_done), .pass(z_pass), .fail(z_fail), .timeout(z_timeout),
    .fail_testnum(z_tn), .cycles(z_cyc)
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
  endtask

  // clr everything, then arm; returns in the first RUN cycle (cycles=0)
  task automatic start();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    checks++;
    if ({m_busy, m_done, m_pass, m_fail, m_timeout} !== 5'b0 || m_tn !== 32'd0 || m_cyc !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: flags=%b tn=%0d cyc=%0d, need all 0",
               {m_busy, m_done, m_pass, m_fail, m_timeout}, m_tn, m_cyc);
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_pass_path();
    start();
    wr(5'd3, 32'd5);
    wr(5'd27, 32'd1);
    idle(38);
    wr(5'd26, 32'd1);
    checks++;
    if (m_busy !== 1'b1 || m_cyc !== 32'd40) begin
      errors++;
      $display("FAIL pass_drain_entry: busy=%b cyc=%0d, need busy=1 cyc=40", m_busy, m_cyc);
    end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checks++;
      if (m_done !== 1'b0 || m_busy !== 1'b1) begin
        errors++;
        $display("FAIL pass_latency: drain cycle %0d done=%b busy=%b, need done=0 busy=1", i, m_done, m_busy);
      end
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_fail !== 1'b0 || m_busy !== 1'b0 ||
        m_tn !== 32'd5 || m_cyc !== 32'd40) begin
      errors++;
      $display("FAIL pass_verdict: done=%b pass=%b fail=%b busy=%b tn=%0d cyc=%0d, need 1 1 0 0 5 40",
               m_done, m_pass, m_fail, m_busy, m_tn, m_cyc);
    end
  endtask

  task automatic test_fail_path();
    start();
    wr(5'd3, 32'd7);
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    idle(10);
    checks++;
    if (m_fail !== 1'b1 || m_pass !== 1'b0 || m_timeout !== 1'b0 || m_tn !== 32'd7) begin
      errors++;
      $display("FAIL fail_verdict: fail=%b pass=%b timeout=%b tn=%0d, need 1 0 0 7",
               m_fail, m_pass, m_timeout, m_tn);
    end
  endtask

  task automatic test_late_result();
    start();
    wr(5'd26, 32'd1);
    idle(9);
    wr(5'd27, 32'd1);
    checks++;
    if (m_pass !== 1'b1 || m_fail !== 1'b0) begin
      errors++;
      $display("FAIL late_result_last_cycle: pass=%b fail=%b, need pass=1", m_pass, m_fail);
    end
    start();
    wr(5'd26, 32'd1);
    idle(10);
    wr(5'd27, 32'd1);
    idle(3);
    checks++;
    if (m_fail !== 1'b1 || m_pass !== 1'b0 || m_done !== 1'b1) begin
      errors++;
      $display("FAIL late_result_after_verdict: pass=%b fail=%b done=%b, need fail=1 done=1",
               m_pass, m_fail, m_done);
    end
  endtask

  task automatic test_timeout();
    start();
    wr(5'd3, 32'd9);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 47) begin
        checks++;
        if (t_timeout !== 1'b0 || t_busy !== 1'b1 || t_cyc !== 32'd49) begin
          errors++;
          $display("FAIL timeout_early: timeout=%b busy=%b cyc=%0d, need 0 1 49", t_timeout, t_busy, t_cyc);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (t_timeout !== 1'b1 || t_fail !== 1'b1 || t_pass !== 1'b0 || t_cyc !== 32'd49 || t_tn !== 32'd9) begin
      errors++;
      $display("FAIL timeout_verdict: timeout=%b fail=%b pass=%b cyc=%0d tn=%0d, need 1 1 0 49 9",
               t_timeout, t_fail, t_pass, t_cyc, t_tn);
    end
    start();
    idle(49);
    wr(5'd26, 32'd1);
    checks++;
    if (t_busy !== 1'b1 || t_timeout !== 1'b0 || t_done !== 1'b0 || t_cyc !== 32'd49) begin
      errors++;
      $display("FAIL timeout_done_wins: busy=%b timeout=%b done=%b cyc=%0d, need 1 0 0 49",
               t_busy, t_timeout, t_done, t_cyc);
    end
  endtask

  task automatic test_filtering();
    start();
    wr(5'd26, 32'd2);
    wr(5'd26, 32'hFFFF_FFFF);
    wr_en = 1'b0; wr_addr = 5'd26; wr_data = 32'd1;
    @(negedge clk);
    wr_addr = 5'd0; wr_data = 32'd0;
    wr(5'd0, 32'd1);
    idle(15);
    checks++;
    if (m_busy !== 1'b1 || m_done !== 1'b0 || m_cyc !== 32'd19) begin
      errors++;
      $display("FAIL filter_main: busy=%b done=%b cyc=%0d, need 1 0 19", m_busy, m_done, m_cyc);
    end
    checks++;
    if (z_busy !== 1'b1 || z_done !== 1'b0) begin
      errors++;
      $display("FAIL filter_x0_done_reg: busy=%b done=%b, need 1 0", z_busy, z_done);
    end
  endtask

  task automatic test_reset_clr();
    start();
    wr(5'd26, 32'd1);
    idle(3);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_busy, m_done, m_pass, m_fail, m_timeout} !== 5'b0 || m_tn !== 32'd0 || m_cyc !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b tn=%0d cyc=%0d, need all 0",
               {m_busy, m_done, m_pass, m_fail, m_timeout}, m_tn, m_cyc);
    end
    @(negedge clk);
    rst = 1'b1;
    start();
    wr(5'd3, 32'd4);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    idle(10);
    checks++;
    if (m_pass !== 1'b1 || m_tn !== 32'd4) begin
      errors++;
      $display("FAIL clr_setup_pass: pass=%b tn=%0d, need 1 4", m_pass, m_tn);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_pass !== 1'b0 || m_tn !== 32'd0 || m_cyc !== 32'd0) begin
      errors++;
      $display("FAIL clr_to_idle: busy=%b done=%b pass=%b tn=%0d cyc=%0d, need all 0",
               m_busy, m_done, m_pass, m_tn, m_cyc);
    end
    mon_en = 1'b1;
    @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (m_busy !== 1'b1 || m_cyc !== 32'd0) begin
      errors++;
      $display("FAIL restart_run: busy=%b cyc=%0d, need 1 0", m_busy, m_cyc);
    end
    @(negedge clk);
    checks++;
    if (m_cyc !== 32'd1) begin
      errors++;
      $display("FAIL restart_count: cyc=%0d, need 1", m_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_pass_path();
    test_fail_path();
    test_late_result();
    test_timeout();
    test_filtering();
    test_reset_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
